// File: rtl/char_sprite_fetcher.sv
// Per-pixel sprite fetch for Pac-Man and four ghosts. Positions are shadowed
// once per frame, each pixel is hit-tested against every sprite, and the ROM
// addresses are registered. Returned ROM data is remapped for ghost state,
// giving a fixed two-cycle latency.

// Bounding-box test for one 16x16 sprite. An 11-bit subtract exposes the
// borrow, so a pixel left of or above the sprite can never wrap into a hit.
module sprite_hit (
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    output logic       hit,
    output logic [3:0] row,
    output logic [3:0] col
);
    logic [10:0] dx, dy;

    assign dx  = {1'b0, pix_x} - {1'b0, obj_x};
    assign dy  = {1'b0, pix_y} - {1'b0, obj_y};
    assign hit = ~dx[10] & ~dy[10] & (dx[9:4] == 6'd0) & (dy[9:4] == 6'd0);
    assign row = dy[3:0];
    assign col = dx[3:0];
endmodule

module char_sprite_fetcher #(
    parameter int ANIM_FRAMES  = 8,
    parameter int FLASH_FRAMES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_valid,
    input  logic [9:0]  i_pix_x,
    input  logic [9:0]  i_pix_y,
    input  logic        i_frame_start,
    input  logic [9:0]  i_pacman_x,
    input  logic [9:0]  i_pacman_y,
    input  logic [1:0]  i_pacman_dir,
    input  logic [39:0] i_ghost_x,
    input  logic [39:0] i_ghost_y,
    input  logic [3:0]  i_ghost_en,
    input  logic [3:0]  i_ghost_fright,
    input  logic [3:0]  i_ghost_eaten,
    input  logic        i_fright_ending,
    output logic [10:0] o_pac_rom_addr,
    input  logic        i_pac_rom_data,
    output logic [8:0]  o_ghost_rom_addr,
    input  logic [1:0]  i_ghost_rom_data,
    output logic        o_valid,
    output logic [3:0]  o_which_char,
    output logic [1:0]  o_data_ghost,
    output logic        o_data_pacman
);
    localparam int NUM_GHOSTS = 4;

    // Frame-stable copies of the sprite state
    logic [9:0]  sh_pac_x, sh_pac_y;
    logic [1:0]  sh_pac_dir;
    logic [39:0] sh_ghost_x, sh_ghost_y;
    logic [3:0]  sh_en, sh_fright, sh_eaten;
    logic        sh_fr_end;

    logic [15:0] anim_cnt, flash_cnt;
    logic        anim, flash;

    // vld_pipe[0]: ROM request stage, vld_pipe[1]: output stage
    logic [1:0]  vld_pipe;
    logic        s1_pac_hit, s1_g_hit, s1_fright, s1_eaten, s1_flash;
    logic [2:0]  s1_idx;

    logic                        pac_hit;
    logic [3:0]                  pac_row, pac_col;
    logic [NUM_GHOSTS-1:0]       g_raw, g_hit;
    logic [NUM_GHOSTS-1:0][3:0]  g_row, g_col;
    logic                        win_hit, win_fr, win_ea;
    logic [2:0]                  win_idx;
    logic [3:0]                  win_row, win_col;
    logic [1:0]                  g_remap;

    // Capture sprite state only on the frame pulse; that pixel still sees the old copy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_pac_x   <= '0;
            sh_pac_y   <= '0;
            sh_pac_dir <= '0;
            sh_ghost_x <= '0;
            sh_ghost_y <= '0;
            sh_en      <= '0;
            sh_fright  <= '0;
            sh_eaten   <= '0;
            sh_fr_end  <= 1'b0;
        end else if (i_frame_start) begin
            sh_pac_x   <= i_pacman_x;
            sh_pac_y   <= i_pacman_y;
            sh_pac_dir <= i_pacman_dir;
            sh_ghost_x <= i_ghost_x;
            sh_ghost_y <= i_ghost_y;
            sh_en      <= i_ghost_en;
            sh_fright  <= i_ghost_fright;
            sh_eaten   <= i_ghost_eaten;
            sh_fr_end  <= i_fright_ending;
        end
    end

    // Animation phase toggles every ANIM_FRAMES frame pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            anim_cnt <= '0;
            anim     <= 1'b0;
        end else if (i_frame_start) begin
            if (anim_cnt == 16'(ANIM_FRAMES - 1)) begin
                anim_cnt <= '0;
                anim     <= ~anim;
            end else begin
                anim_cnt <= anim_cnt + 16'd1;
            end
        end
    end

    // Flash phase runs only once the shadowed fright-ending flag is set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flash_cnt <= '0;
            flash     <= 1'b0;
        end else if (i_frame_start) begin
            if (!sh_fr_end) begin
                flash_cnt <= '0;
                flash     <= 1'b0;
            end else if (flash_cnt == 16'(FLASH_FRAMES - 1)) begin
                flash_cnt <= '0;
                flash     <= ~flash;
            end else begin
                flash_cnt <= flash_cnt + 16'd1;
            end
        end
    end

    sprite_hit u_pac_hit (
        .pix_x (i_pix_x),
        .pix_y (i_pix_y),
        .obj_x (sh_pac_x),
        .obj_y (sh_pac_y),
        .hit   (pac_hit),
        .row   (pac_row),
        .col   (pac_col)
    );

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        sprite_hit u_hit (
            .pix_x (i_pix_x),
            .pix_y (i_pix_y),
            .obj_x (sh_ghost_x[10*g +: 10]),
            .obj_y (sh_ghost_y[10*g +: 10]),
            .hit   (g_raw[g]),
            .row   (g_row[g]),
            .col   (g_col[g])
        );
        assign g_hit[g] = g_raw[g] & sh_en[g];
    end

    // Lowest-numbered visible ghost wins; scanning downward lets it overwrite
    always_comb begin
        win_hit = 1'b0;
        win_idx = 3'd0;
        win_row = 4'd0;
        win_col = 4'd0;
        win_fr  = 1'b0;
        win_ea  = 1'b0;
        for (int g = NUM_GHOSTS - 1; g >= 0; g--) begin
            if (g_hit[g]) begin
                win_hit = 1'b1;
                win_idx = 3'(g + 1);
                win_row = g_row[g];
                win_col = g_col[g];
                win_fr  = sh_fright[g];
                win_ea  = sh_eaten[g];
            end
        end
    end

    // Stage 0 -> 1: register ROM addresses and per-pixel hit context
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe[0]      <= 1'b0;
            s1_pac_hit       <= 1'b0;
            s1_g_hit         <= 1'b0;
            s1_idx           <= '0;
            s1_fright        <= 1'b0;
            s1_eaten         <= 1'b0;
            s1_flash         <= 1'b0;
            o_pac_rom_addr   <= '0;
            o_ghost_rom_addr <= '0;
        end else begin
            vld_pipe[0]      <= i_pix_valid;
            s1_pac_hit       <= i_pix_valid & pac_hit;
            s1_g_hit         <= i_pix_valid & win_hit;
            s1_idx           <= win_idx;
            s1_fright        <= win_fr;
            s1_eaten         <= win_ea;
            s1_flash         <= flash;
            o_pac_rom_addr   <= {sh_pac_dir, anim, pac_row, pac_col};
            o_ghost_rom_addr <= {anim, win_row, win_col};
        end
    end

    // Ghost state remap: eaten shows eyes only, frightened recolours body/pupil
    always_comb begin
        g_remap = i_ghost_rom_data;
        if (s1_eaten) begin
            if (i_ghost_rom_data == 2'd3) g_remap = 2'd0;
        end else if (s1_fright) begin
            if (i_ghost_rom_data == 2'd3)      g_remap = s1_flash ? 2'd2 : 2'd1;
            else if (i_ghost_rom_data == 2'd1) g_remap = 2'd2;
        end
    end

    // Stage 1 -> output: hit flags already include valid, so misses give zeros
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe[1]   <= 1'b0;
            o_which_char  <= '0;
            o_data_ghost  <= '0;
            o_data_pacman <= 1'b0;
        end else begin
            vld_pipe[1]   <= vld_pipe[0];
            o_which_char  <= s1_g_hit ? {1'b0, s1_idx} : 4'd0;
            o_data_ghost  <= s1_g_hit ? g_remap : 2'd0;
            o_data_pacman <= s1_pac_hit & i_pac_rom_data;
        end
    end

    assign o_valid = vld_pipe[1];
endmodule

// File: doc/char_sprite_fetcher.md
Name: char_sprite_fetcher

Overview:
- Per-pixel sprite engine that sits directly upstream of the character colour decoder.
- For each active VGA pixel it finds which character (Pac-Man, ghost 1-4) covers the pixel and reads the sprite ROMs.
- It applies frightened, eaten and flash remapping to the ghost pixel, then emits the raw pixel codes and character index consumed by the decoder.
- It also owns the per-frame animation and flash timers, and latches character positions once per frame to prevent tearing.

Parameters:
- ANIM_FRAMES, 8, frames per animation phase toggle (mouth/skirt frame); legal range >= 1.
- FLASH_FRAMES, 16, frames per flash phase toggle while fright is ending; legal range >= 1.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  current pixel is in the active area
- i_pix_x  in  10  current pixel column
- i_pix_y  in  10  current pixel row
- i_frame_start  in  1  one-cycle pulse, asserted during vertical blanking
- i_pacman_x, i_pacman_y  in  10 each  top-left of the Pac-Man sprite
- i_pacman_dir  in  2  0 right, 1 left, 2 up, 3 down
- i_ghost_x, i_ghost_y  in  40 each  4x10 packed; ghost k (1..4) occupies bits [10k-1:10k-10]
- i_ghost_en  in  4  ghost visible; bit k-1 is ghost k
- i_ghost_fright  in  4  ghost frightened
- i_ghost_eaten  in  4  ghost eaten (eyes only)
- i_fright_ending  in  1  frightened period about to expire
- o_pac_rom_addr  out  11  {dir[1:0], anim, row[3:0], col[3:0]}
- i_pac_rom_data  in  1  Pac-Man ROM data
- o_ghost_rom_addr  out  9  {anim, row[3:0], col[3:0]}
- i_ghost_rom_data  in  2  ghost ROM data; 0 transparent, 1 pupil, 2 eye white, 3 body
- o_valid  out  1  output pixel valid
- o_which_char  out  4  0 none, 1..4 ghost index
- o_data_ghost  out  2  remapped ghost pixel code
- o_data_pacman  out  1  Pac-Man pixel on

Behaviour:
- Reset is asynchronous. Every output register, shadow position/enable/flag register, counter and phase bit resets to 0.
- Shadow latch:
  - On a cycle with i_frame_start=1, all position, dir, en, fright and eaten inputs are captured into shadow registers.
  - Pixels strictly after that cycle use the new values. A pixel coincident with i_frame_start uses the old values.
  - Inputs are ignored at all other times.
  - i_fright_ending is also shadowed at frame start.
- Animation counter:
  - Increments on each i_frame_start.
  - On reaching ANIM_FRAMES-1 it wraps to 0 and toggles anim (takes effect with the new shadow values).
- Flash counter:
  - While the shadowed fright_ending=0, the counter and the flash phase are held at 0.
  - Otherwise the counter counts frames like anim, toggling flash at FLASH_FRAMES-1.
- Hit test (stage 0, the cycle the pixel is presented):
  - dx = i_pix_x - obj_x and dy = i_pix_y - obj_y, computed in 11 bits.
  - Hit iff there is no borrow and both dx < 16 and dy < 16. Objects near 0 must never alias, e.g. a pixel left of the sprite wraps and misses.
  - Ghost hits are gated by en.
  - Among overlapping ghosts, the lowest index wins.
  - Pac-Man and ghost are evaluated independently; both may hit the same pixel.
- Pipeline:
  - Stage 0 registers the ROM addresses, the hit flags, the winning ghost index and its fright/eaten bits, plus valid, into stage 1.
  - The ROMs return data during stage 1; 1-cycle read latency is fixed.
  - Stage 1 remaps and registers the outputs.
  - Total latency is 2 cycles: a pixel presented in cycle t appears on the outputs in cycle t+2.
  - Throughput is one pixel per cycle, with no stalls.
- Remap of ghost data d for the winning ghost:
  - eaten: body 3 becomes 0; other codes unchanged.
  - frightened and not eaten: 3 becomes 1 when flash=0, or 2 when flash=1; 1 becomes 2; 2 is unchanged.
  - otherwise: d passes through unchanged.
- Output rules:
  - On a ghost miss, o_which_char=0 and o_data_ghost=0.
  - On a ghost hit, o_which_char = the ghost index, even if the remapped data is 0.
  - o_data_pacman = i_pac_rom_data on a Pac-Man hit, else 0.
  - If the pixel is invalid, o_valid=0 and all data outputs are 0.
  - ROM addresses are don't-care on a miss but must be registered values, never combinational.
- Reset asserted mid-line: the pipeline flushes immediately, and outputs are zero until 2 cycles after the first valid pixel following release.

Test Plan:
- Reset with all inputs toggling -> all outputs 0; anim=0; flash=0; shadows 0.
- Pac-Man at (100,50), dir=2, frame start, then pixel (103,52) in cycle t -> o_pac_rom_addr=11'b10_0_0010_0011 at t+1; ROM data 1 -> o_data_pacman=1, o_valid=1 at t+2.
- Boundaries with ghost 1 at (200,200) -> pixels x=215 hit, x=216 miss, x=199 miss. Ghost at x=0: pixel x=1023 must miss.
- Ghosts 2 and 4 overlapping at the same pixel, ROM data 3 -> o_which_char=2, o_data_ghost=3. Disable ghost 2 at the next frame -> o_which_char=4.
- Ghost 3 frightened with fright_ending=1 and FLASH_FRAMES=16, ROM data 3 -> o_data_ghost=1 for frames 0-15 and 2 for frames 16-31. Eaten ghost with data 3 -> 0 while o_which_char=3.
- Change i_pacman_x mid-frame without a frame pulse -> hits still follow the old x; the new x takes effect from the cycle after the next i_frame_start. Anim toggles every 8 frame pulses.
